// File: rtl/gprf_multiport_if.sv
// Register-file port bundle: two read ports, two write ports and the clear request/status.
interface gprf_multiport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] address_A;
    logic [ADDR_WIDTH-1:0] address_B;
    logic [ADDR_WIDTH-1:0] address_W0;
    logic [DATA_WIDTH-1:0] write_data0;
    logic                  write_enable0;
    logic [ADDR_WIDTH-1:0] address_W1;
    logic [DATA_WIDTH-1:0] write_data1;
    logic                  write_enable1;
    logic                  clear_req;
    logic [DATA_WIDTH-1:0] reg_A;
    logic [DATA_WIDTH-1:0] reg_B;
    logic                  clear_busy;
    logic                  clear_done;

    modport master (
        output address_A, address_B,
        output address_W0, write_data0, write_enable0,
        output address_W1, write_data1, write_enable1,
        output clear_req,
        input  reg_A, reg_B, clear_busy, clear_done
    );

    modport slave (
        input  address_A, address_B,
        input  address_W0, write_data0, write_enable0,
        input  address_W1, write_data1, write_enable1,
        input  clear_req,
        output reg_A, reg_B, clear_busy, clear_done
    );
endinterface

// File: rtl/gprf_multiport.sv
// 2-read / 2-write register file with optional bypass and a one-entry-per-cycle clear engine.
// Reads are combinational (0 cycles); writes commit on the edge; no backpressure, clear takes NUM_REGS+1 cycles.
module gprf_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic               clk,
    input  logic               rst,
    gprf_multiport_if.slave    bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    logic w_idle;
    logic w_last;
    logic w_wr0;
    logic w_wr1;

    assign w_idle = (r_state == S_IDLE);
    assign w_last = (r_cnt == {ADDR_WIDTH{1'b1}});
    assign w_wr0  = w_idle && bus.write_enable0 &&
                    !((ZERO_REG != 0) && (bus.address_W0 == '0));
    assign w_wr1  = w_idle && bus.write_enable1 &&
                    !((ZERO_REG != 0) && (bus.address_W1 == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.clear_req) w_next_state = S_CLEAR;
            S_CLEAR: if (w_last)        w_next_state = S_DONE;
            S_DONE:                     w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.clear_busy = (r_state == S_CLEAR);
        bus.clear_done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_idle && bus.clear_req) begin
            r_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr0) r_mem[bus.address_W0] <= bus.write_data0;
            if (w_wr1) r_mem[bus.address_W1] <= bus.write_data1;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] v;
        v = r_mem[addr];
        if ((BYPASS != 0) && w_idle) begin
            if (bus.write_enable0 && (bus.address_W0 == addr)) v = bus.write_data0;
            if (bus.write_enable1 && (bus.address_W1 == addr)) v = bus.write_data1;
        end
        if ((ZERO_REG != 0) && (addr == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        bus.reg_A = f_read(bus.address_A);
        bus.reg_B = f_read(bus.address_B);
    end
endmodule

// File: doc/gprf_multiport.md
Name: gprf_multiport

Overview:
Parametrised general purpose register file that succeeds the single-write-port RegisterFile in the MIPS datapath. It provides two combinational read ports and two synchronous write ports with fixed priority, and an optional write-to-read bypass. A sequential clear engine zeroes the whole array on request, one entry per cycle, so the core can flush architectural state without asserting reset.

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports.
ADDR_WIDTH, 5, address width; the array holds NUM_REGS = 2**ADDR_WIDTH entries (derived localparam).
ZERO_REG, 1, when 1, entry 0 reads as 0 and writes to it are discarded.
BYPASS, 1, when 1, reads of an address being written this cycle return the incoming write data.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-low reset
address_A  input  ADDR_WIDTH  read port A address
address_B  input  ADDR_WIDTH  read port B address
address_W0  input  ADDR_WIDTH  write port 0 address
write_data0  input  DATA_WIDTH  write port 0 data
write_enable0  input  1  write port 0 enable
address_W1  input  ADDR_WIDTH  write port 1 address
write_data1  input  DATA_WIDTH  write port 1 data
write_enable1  input  1  write port 1 enable (priority over port 0)
clear_req  input  1  single-cycle request to start an array clear
reg_A  output  DATA_WIDTH  read port A data
reg_B  output  DATA_WIDTH  read port B data
clear_busy  output  1  high while the clear engine runs
clear_done  output  1  one-cycle pulse after the last entry is cleared

Behaviour:
- Reset (rst low, asynchronous): all entries go to 0, the FSM goes to IDLE, the clear counter goes to 0, and clear_busy and clear_done go to 0. reg_A and reg_B therefore read 0.
- Writes: commit on the rising clk edge while the FSM is IDLE. Each enabled port writes its entry.
- Same address on both write ports with both enabled: port 1 data is stored and port 0 is dropped.
- ZERO_REG=1: a write to address 0 is ignored, and reading address 0 returns 0 regardless of bypass.
- Reads: combinational, with zero-cycle latency from address to data. When BYPASS=0, a read returns the pre-edge contents.
- Bypass (BYPASS=1, FSM IDLE): if a read address matches an enabled write address in the same cycle, the read returns that write data. When both write ports match, port 1 takes priority. The read otherwise returns the array entry.
- Clear FSM states: IDLE, CLEAR, DONE.
- IDLE -> CLEAR: on a rising edge with clear_req=1. The counter loads 0 and clear_busy rises in the next cycle.
- CLEAR: each edge zeroes the entry at the counter and increments the counter. After the edge that clears entry NUM_REGS-1, the FSM goes to DONE. The counter width is ADDR_WIDTH, and the transition is taken on the terminal count, not on wrap-around.
- DONE: clear_done=1 and clear_busy=0 for exactly one cycle, then the FSM returns to IDLE. Total cost from request to done is NUM_REGS+1 cycles.
- During CLEAR: both user writes are discarded, bypass is disabled, and reads return current array contents, so entries below the counter read 0.
- clear_req while CLEAR or DONE: ignored, not queued.
- clear_req and a write in the same IDLE cycle: the write commits on that edge and the entry is then cleared during CLEAR.
- Reset mid-CLEAR: the clear aborts, all entries are 0, the FSM is IDLE, and no clear_done pulse is produced.

Test Plan:
- Reset, then write0 addr 5 = 0xDEADBEEF; after the edge, address_A=5 -> reg_A=0xDEADBEEF and reg_B at addr 6 = 0.
- Both ports write addr 9 (port0 0x11111111, port1 0x22222222) -> after the edge, reg_A at addr 9 = 0x22222222.
- BYPASS=1: write1 addr 3 = 0x0000CAFE with address_B=3 in the same cycle -> reg_B=0x0000CAFE before the edge. Repeat with BYPASS=0 -> reg_B shows the old value 0.
- ZERO_REG=1: write addr 0 = 0xFFFFFFFF with bypass active -> reg_A at addr 0 = 0 both before and after the edge.
- Fill entries 1..31 with nonzero values, then pulse clear_req -> clear_busy is high for exactly 32 cycles, then clear_done pulses for 1 cycle. A write to addr 7 mid-clear is lost, and every entry reads 0 afterwards.
- Start a clear, assert rst low after 10 cycles -> busy and done are 0 immediately, all entries read 0, and no clear_done pulse appears. A subsequent write to addr 4 = 0x12345678 reads back correctly.
